ucc_seq_converter: RTL and testbench

- Clocked, parametrised successor to the combinational universal code converter.
- Converts a DIGITS-digit word between four codes: binary, Gray, BCD and excess-3.
- Uses a valid/ready handshake on both sides and a multi-cycle FSM (iterative BCD decode, double-dabble encode).
- Flags unrepresentable or illegal inputs and keeps a saturating error count.
- Sits between the input selector logic and the display/output stage.

---
 rtl/ucc_pkg.sv | 36 +++
 rtl/ucc_dabble_step.sv | 21 ++
 rtl/ucc_seq_converter.sv | 201 ++++++++++++++++++++
 tb/tb_ucc_seq_converter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ucc_pkg.sv
// Shared definitions for the sequential universal code converter:
// code selectors, FSM state encoding and constant helper functions.
package ucc_pkg;

    localparam logic [1:0] CODE_BIN  = 2'd0;
    localparam logic [1:0] CODE_GRAY = 2'd1;
    localparam logic [1:0] CODE_BCD  = 2'd2;
    localparam logic [1:0] CODE_XS3  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ENCODE = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int clog2(input longint unsigned v);
        int r;
        longint unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return r;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/ucc_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// the whole BCD word left by one, taking bit_in into the LSB.
module ucc_dabble_step #(
    parameter int DIGITS = 2
) (
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic                bit_in,
    output logic [4*DIGITS-1:0] bcd_out
);

    logic [4*DIGITS-1:0] adj;

    always_comb begin
        adj = bcd_in;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
        end
        bcd_out = {adj[4*DIGITS-2:0], bit_in};
    end

endmodule

// File: rtl/ucc_seq_converter.sv
// Multi-cycle converter between binary, Gray, BCD and excess-3 words with
// valid/ready handshakes, error flagging and a saturating error counter.
module ucc_seq_converter
    import ucc_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] in_data,
    input  logic [1:0]          selin,
    input  logic [1:0]          selout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_data,
    output logic                out_err,
    output logic                busy,
    output logic [CNT_W-1:0]    err_count
);

    localparam int              W      = 4 * DIGITS;
    localparam longint unsigned MAXV   = pow10(DIGITS) - 1;
    localparam int              BW     = clog2(MAXV + 1);
    localparam int              SW     = clog2(BW) + 1;
    localparam logic [W-1:0]    MAXV_W = W'(MAXV);

    state_t           state, state_d;
    logic [W-1:0]     word_r, word_d;
    logic [1:0]       selin_r, selin_d, selout_r, selout_d;
    logic [BW-1:0]    acc_r, acc_d;
    logic             err_r, err_d;
    logic [SW-1:0]    step_r, step_d;
    logic [W-1:0]     bcd_r, bcd_d;
    logic [W-1:0]     out_data_d;
    logic             out_err_d;
    logic [CNT_W-1:0] err_count_d;

    logic [W-1:0]     gray_bin;
    logic [W-1:0]     dab_out;
    logic [3:0]       nib, digit;
    logic [BW+3:0]    acc_mac;
    logic             cur_err, dec_last;
    logic [BW-1:0]    dec_val;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [W-1:0] add_xs3(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        return r;
    endfunction

    assign gray_bin  = gray2bin(word_r);
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    ucc_dabble_step #(.DIGITS(DIGITS)) u_dabble (
        .bcd_in  (bcd_r),
        .bit_in  (acc_r[BW-1]),
        .bcd_out (dab_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_r    <= '0;
            selin_r   <= CODE_BIN;
            selout_r  <= CODE_BIN;
            acc_r     <= '0;
            err_r     <= 1'b0;
            step_r    <= '0;
            bcd_r     <= '0;
            out_data  <= '0;
            out_err   <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_d;
            word_r    <= word_d;
            selin_r   <= selin_d;
            selout_r  <= selout_d;
            acc_r     <= acc_d;
            err_r     <= err_d;
            step_r    <= step_d;
            bcd_r     <= bcd_d;
            out_data  <= out_data_d;
            out_err   <= out_err_d;
            err_count <= err_count_d;
        end
    end

    // Digit-serial decoders consume the MS nibble of word_r, which shifts left each cycle.
    always_comb begin
        nib      = word_r[W-1 -: 4];
        digit    = nib;
        cur_err  = 1'b0;
        dec_last = 1'b1;
        unique case (selin_r)
            CODE_BIN: cur_err = (word_r > MAXV_W);
            CODE_GRAY: cur_err = (gray_bin > MAXV_W);
            CODE_BCD: begin
                cur_err  = (nib > 4'd9);
                dec_last = (step_r == SW'(DIGITS - 1));
            end
            default: begin
                digit    = nib - 4'd3;
                cur_err  = (nib < 4'd3) || (nib > 4'd12);
                dec_last = (step_r == SW'(DIGITS - 1));
            end
        endcase
        acc_mac = {4'd0, acc_r} * (BW+4)'(10) + (BW+4)'(digit);
        unique case (selin_r)
            CODE_BIN:  dec_val = word_r[BW-1:0];
            CODE_GRAY: dec_val = gray_bin[BW-1:0];
            default:   dec_val = acc_mac[BW-1:0];
        endcase
    end

    always_comb begin
        state_d     = state;
        word_d      = word_r;
        selin_d     = selin_r;
        selout_d    = selout_r;
        acc_d       = acc_r;
        err_d       = err_r;
        step_d      = step_r;
        bcd_d       = bcd_r;
        out_data_d  = out_data;
        out_err_d   = out_err;
        err_count_d = err_count;

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    word_d   = in_data;
                    selin_d  = selin;
                    selout_d = selout;
                    acc_d    = '0;
                    err_d    = 1'b0;
                    step_d   = '0;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                acc_d  = dec_val;
                err_d  = err_r | cur_err;
                word_d = word_r << 4;
                step_d = step_r + SW'(1);
                if (dec_last) begin
                    step_d = '0;
                    bcd_d  = '0;
                    if (err_r | cur_err) begin
                        state_d    = DONE;
                        out_data_d = '0;
                        out_err_d  = 1'b1;
                        if (err_count != {CNT_W{1'b1}}) err_count_d = err_count + CNT_W'(1);
                    end else begin
                        state_d = ENCODE;
                    end
                end
            end
            ENCODE: begin
                unique case (selout_r)
                    CODE_BIN: begin
                        out_data_d = {{(W-BW){1'b0}}, acc_r};
                        out_err_d  = 1'b0;
                        state_d    = DONE;
                    end
                    CODE_GRAY: begin
                        out_data_d = {{(W-BW){1'b0}}, acc_r ^ (acc_r >> 1)};
                        out_err_d  = 1'b0;
                        state_d    = DONE;
                    end
                    default: begin
                        bcd_d  = dab_out;
                        acc_d  = acc_r << 1;
                        step_d = step_r + SW'(1);
                        if (step_r == SW'(BW - 1)) begin
                            out_data_d = (selout_r == CODE_XS3) ? add_xs3(dab_out) : dab_out;
                            out_err_d  = 1'b0;
                            state_d    = DONE;
                        end
                    end
                endcase
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ucc_seq_converter.sv
// Scoreboard bench for ucc_seq_converter (DIGITS=2); a second instance with
// CNT_W=2 shares all stimulus to exercise error-counter saturation.
module tb_ucc_seq_converter;
    import ucc_pkg::*;

    localparam int DIGITS = 2;
    localparam int W      = 8;
    localparam int BW     = 7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in_data = '0;
    logic [1:0]   selin = CODE_BIN;
    logic [1:0]   selout = CODE_BIN;

    logic         in_ready, out_valid, out_err, busy;
    logic [W-1:0] out_data;
    logic [7:0]   err_count;
    logic         in_ready2, out_valid2, out_err2, busy2;
    logic [W-1:0] out_data2;
    logic [1:0]   err_count2;

    typedef struct packed {
        logic [W-1:0] data;
        logic         err;
        logic [7:0]   lat;
    } exp_t;

    exp_t sb[$];
    int   num_checks = 0;
    int   num_errors = 0;
    int   err_model  = 0;
    int   sat_model  = 0;

    ucc_seq_converter #(.DIGITS(DIGITS), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .selin(selin), .selout(selout), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .busy(busy), .err_count(err_count)
    );

    ucc_seq_converter #(.DIGITS(DIGITS), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .selin(selin), .selout(selout), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .out_err(out_err2),
        .busy(busy2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [W-1:0] data, input logic [1:0] si,
                                 input logic [1:0] so, input logic [W-1:0] exp_data,
                                 input logic exp_err, input int hold);
        exp_t e;
        int   lat;
        int   guard;
        logic [W-1:0] held;
        e.data = exp_data;
        e.err  = exp_err;
        e.lat  = 8'(((si == CODE_BCD || si == CODE_XS3) ? DIGITS : 1) +
                    (exp_err ? 0 : ((so == CODE_BCD || so == CODE_XS3) ? BW : 1)));
        sb.push_back(e);
        if (exp_err) begin
            err_model++;
            if (sat_model < 3) sat_model++;
        end

        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_data   = data;
        selin     = si;
        selout    = so;
        out_ready = (hold == 0);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput({tag, "/in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~data;
        selin    = ~si;
        selout   = ~so;
        checkOutput({tag, "/busy"}, 32'({busy, busy2, in_ready, in_ready2}), 32'b1100);

        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        checkOutput({tag, "/latency"}, 32'(lat), 32'(e.lat));
        checkOutput({tag, "/data"}, 32'(out_data), 32'(e.data));
        checkOutput({tag, "/err"}, 32'(out_err), 32'(e.err));
        checkOutput({tag, "/sat_dut"}, 32'({out_valid2, out_err2, out_data2}), 32'({1'b1, e.err, e.data}));
        checkOutput({tag, "/err_count"}, 32'(err_count), 32'(err_model));
        checkOutput({tag, "/err_count_sat"}, 32'(err_count2), 32'(sat_model));

        if (hold > 0) begin
            held = out_data;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                checkOutput({tag, "/hold"}, 32'({out_valid, in_ready, out_err, out_data}),
                            32'({1'b1, 1'b0, e.err, e.data}));
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            checkOutput({tag, "/release"}, 32'({out_valid, in_ready, out_data}), 32'({1'b0, 1'b1, held}));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset", 32'({in_ready, out_valid, out_err, busy, out_data, err_count}),
                    32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}));
        rst_n = 1'b1;

        applyStimulus("bin45_bcd",  8'd45,  CODE_BIN,  CODE_BCD,  8'h45, 1'b0, 0);
        applyStimulus("bcd59_gray", 8'h59,  CODE_BCD,  CODE_GRAY, 8'h26, 1'b0, 0);
        applyStimulus("xs37c_bin",  8'h7C,  CODE_XS3,  CODE_BIN,  8'h31, 1'b0, 0);
        applyStimulus("bin100_err", 8'd100, CODE_BIN,  CODE_BCD,  8'h00, 1'b1, 0);
        applyStimulus("bcd3a_err",  8'h3A,  CODE_BCD,  CODE_BIN,  8'h00, 1'b1, 0);
        applyStimulus("xs32c_err",  8'h2C,  CODE_XS3,  CODE_BCD,  8'h00, 1'b1, 0);
        applyStimulus("bcd07_hold", 8'h07,  CODE_BCD,  CODE_BCD,  8'h07, 1'b0, 5);
        applyStimulus("gray26_xs3", 8'h26,  CODE_GRAY, CODE_XS3,  8'h8C, 1'b0, 0);

        // Reset during ENCODE of BIN 99 -> BCD: everything clears at once.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'd99;
        selin    = CODE_BIN;
        selout   = CODE_BCD;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset", 32'({in_ready, out_valid, out_err, busy, out_data, err_count, err_count2}),
                    32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00}));
        err_model = 0;
        sat_model = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        applyStimulus("bin99_bcd",  8'd99,  CODE_BIN,  CODE_BCD,  8'h99, 1'b0, 0);
        applyStimulus("grayff_err", 8'hFF,  CODE_GRAY, CODE_BIN,  8'h00, 1'b1, 0);
        applyStimulus("bin200_err", 8'd200, CODE_BIN,  CODE_GRAY, 8'h00, 1'b1, 0);
        applyStimulus("bcda0_err",  8'hA0,  CODE_BCD,  CODE_BIN,  8'h00, 1'b1, 0);
        applyStimulus("xs300_err",  8'h00,  CODE_XS3,  CODE_GRAY, 8'h00, 1'b1, 0);
        applyStimulus("xs3d3_err",  8'hD3,  CODE_XS3,  CODE_BCD,  8'h00, 1'b1, 0);
        applyStimulus("xs333_bin",  8'h33,  CODE_XS3,  CODE_BIN,  8'h00, 1'b0, 0);
        applyStimulus("bin0_xs3",   8'd0,   CODE_BIN,  CODE_XS3,  8'h33, 1'b0, 0);
        applyStimulus("bcd99_xs3",  8'h99,  CODE_BCD,  CODE_XS3,  8'hCC, 1'b0, 0);

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
